// File: rtl/five_operand_add_ctrl.sv
// Five-operand adder front end: synchronizes and debounces the lab buttons, latches
// operands from the switches, and sums them through one shared accumulator.
module five_operand_add_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned OP_W            = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        PB,
  input  logic              RPB,
  input  logic [OP_W-1:0]   Y,
  output logic [OP_W+2:0]   sum,
  output logic              sum_valid,
  output logic              busy
);

  localparam int unsigned NUM_OPS = 5;
  localparam int unsigned SUM_W   = OP_W + 3;
  localparam int unsigned CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned IDX_W   = 3;

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_e;

  logic [NUM_OPS-1:0] btn_s1_q, btn_s2_q;
  logic [OP_W-1:0]    y_s1_q, y_s2_q;
  logic [NUM_OPS-1:0] db_q, db_d;
  logic [CNT_W-1:0]   cnt_q [NUM_OPS];
  logic [CNT_W-1:0]   cnt_d [NUM_OPS];
  logic [NUM_OPS-1:0] load_c;

  logic [OP_W-1:0]    op_q [NUM_OPS];
  logic               dirty_q;
  state_e             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [SUM_W-1:0]   acc_q;
  logic [SUM_W-1:0]   sum_q;
  logic               sum_valid_q;
  logic               busy_q;

  assign sum       = sum_q;
  assign sum_valid = sum_valid_q;
  assign busy      = busy_q;

  // Two-flop synchronizers; bit 4 of the button vector is RPB.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_s1_q <= '0;
      btn_s2_q <= '0;
      y_s1_q   <= '0;
      y_s2_q   <= '0;
    end else begin
      btn_s1_q <= {RPB, PB};
      btn_s2_q <= btn_s1_q;
      y_s1_q   <= Y;
      y_s2_q   <= y_s1_q;
    end
  end

  // A level change is accepted after DEBOUNCE_CYCLES consecutive disagreeing cycles.
  always_comb begin
    db_d   = db_q;
    load_c = '0;
    for (int i = 0; i < NUM_OPS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (btn_s2_q[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        cnt_d[i]  = '0;
        db_d[i]   = btn_s2_q[i];
        load_c[i] = btn_s2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      db_q <= '0;
      for (int i = 0; i < NUM_OPS; i++) cnt_q[i] <= '0;
    end else begin
      db_q <= db_d;
      for (int i = 0; i < NUM_OPS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Operand capture and accumulation sequencer; a fresh load always wins over the IDLE clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_OPS; i++) op_q[i] <= '0;
      dirty_q     <= 1'b0;
      state_q     <= IDLE;
      idx_q       <= '0;
      acc_q       <= '0;
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      sum_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (dirty_q) begin
            acc_q   <= '0;
            idx_q   <= '0;
            dirty_q <= 1'b0;
            state_q <= ACC;
            busy_q  <= 1'b1;
          end
        end
        ACC: begin
          acc_q <= acc_q + SUM_W'(op_q[idx_q]);
          idx_q <= idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(NUM_OPS - 1)) state_q <= DONE;
        end
        DONE: begin
          if (!dirty_q) begin
            sum_q       <= acc_q;
            sum_valid_q <= 1'b1;
          end
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
      for (int i = 0; i < NUM_OPS; i++) begin
        if (load_c[i]) op_q[i] <= y_s2_q;
      end
      if (|load_c) dirty_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_five_operand_add_ctrl.sv
// Scoreboard bench for five_operand_add_ctrl: stimulus pushes expected totals and
// publish cycles, a negedge monitor pops and compares on every sum_valid pulse.
module tb_five_operand_add_ctrl;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] PB;
  logic       RPB;
  logic [3:0] Y;
  logic [6:0] sum;
  logic       sum_valid;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit busy_seen;

  typedef struct {
    int sum;
    int cyc;
  } exp_t;
  exp_t sb[$];
  int   ops[5];

  five_operand_add_ctrl #(.DEBOUNCE_CYCLES(DEB), .OP_W(4)) dut (
    .clk(clk), .rst(rst), .PB(PB), .RPB(RPB), .Y(Y),
    .sum(sum), .sum_valid(sum_valid), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (busy) busy_seen = 1'b1;

  function automatic void check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic int model_total();
    int s = 0;
    for (int i = 0; i < 5; i++) s += ops[i];
    return s;
  endfunction

  // Expected publish cycle: 2 sync edges, DEB debounce edges, then IDLE + 5 ACC + DONE.
  function automatic void expect_run(int press_cyc);
    exp_t e;
    e.sum = model_total();
    e.cyc = press_cyc + 2 + DEB + 7;
    sb.push_back(e);
  endfunction

  always @(negedge clk) begin
    if (sum_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_sum_valid: got sum=%0d expected no pulse (cycle %0d)", sum, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sum_value", 32'(sum), e.sum);
        check("sum_latency", cyc, e.cyc);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_btn(input logic [4:0] m);
    PB  = m[3:0];
    RPB = m[4];
  endtask

  task automatic press(input logic [4:0] m, input logic [3:0] y, input int hold, input int gap);
    int c;
    @(negedge clk);
    c = cyc;
    Y = y;
    set_btn(m);
    for (int i = 0; i < 5; i++) if (m[i]) ops[i] = 32'(y);
    expect_run(c);
    idle(hold);
    set_btn(5'b0);
    idle(gap);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int c;
    rst = 1'b1;
    set_btn(5'b0);
    Y = 4'd0;
    for (int i = 0; i < 5; i++) ops[i] = 0;
    idle(3);
    check("reset_sum", 32'(sum), 0);
    check("reset_sum_valid", 32'(sum_valid), 0);
    check("reset_busy", 32'(busy), 0);
    rst = 1'b0;
    idle(2);

    // Bounce shorter than the debounce window never loads.
    busy_seen = 1'b0;
    Y = 4'd7;
    PB = 4'b0001; idle(2);
    PB = 4'b0000; idle(2);
    PB = 4'b0001; idle(3);
    PB = 4'b0000; idle(25);
    check("bounce_busy_seen", 32'(busy_seen), 0);
    check("bounce_sum", 32'(sum), 0);

    // Sequential loads, Y=9, one completed run per press.
    for (int i = 0; i < 5; i++) press(5'(1 << i), 4'd9, 10, 20);
    check("seq_final_sum", 32'(sum), 45);

    // Maximum operands.
    press(5'b11111, 4'd15, 10, 30);
    check("max_sum", 32'(sum), 75);

    // Simultaneous press: one load, one run.
    press(5'b11111, 4'd3, 10, 30);
    check("simul_sum", 32'(sum), 15);

    // Load landing on the second ACC cycle: interrupted run is discarded.
    press(5'b11111, 4'd1, 10, 30);
    @(negedge clk);
    c = cyc;
    Y = 4'd1;
    PB = 4'b0001;
    idle(3);
    PB = 4'b0101;
    idle(2);
    Y = 4'd10;
    ops[2] = 10;
    begin
      exp_t e;
      e.sum = model_total();
      e.cyc = c + 20;
      sb.push_back(e);
    end
    idle(5);
    PB = 4'b0100;
    idle(2);
    check("busy_during_acc", 32'(busy), 1);
    check("sum_held_during_acc", 32'(sum), 5);
    idle(1);
    PB = 4'b0000;
    idle(30);
    check("restart_sum", 32'(sum), 14);

    // Reset during the third ACC cycle aborts the run.
    @(negedge clk);
    Y = 4'd4;
    RPB = 1'b1;
    idle(9);
    RPB = 1'b0;
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) ops[i] = 0;
    check("abort_busy", 32'(busy), 0);
    check("abort_sum", 32'(sum), 0);
    check("abort_sum_valid", 32'(sum_valid), 0);
    idle(20);
    press(5'b10000, 4'd6, 10, 30);
    check("after_abort_sum", 32'(sum), 6);

    // Random well-spaced presses mixed with glitches too short to register.
    for (int k = 0; k < 10; k++) begin
      logic [4:0] m;
      logic [3:0] y;
      m = 5'($urandom_range(1, 31));
      y = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        Y = y;
        set_btn(m);
        idle($urandom_range(1, DEB - 1));
        set_btn(5'b0);
        idle(12);
      end else begin
        press(m, y, $urandom_range(DEB, 12), 25);
      end
    end

    idle(40);
    check("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
